// File: rtl/tqvp_bus_initiator.sv
// Single-command initiator for the TinyQV peripheral data bus: issues one read or write,
// waits for data_ready (or a timeout), then returns the result on a valid/ready response port.
module tqvp_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  per_address,
  output logic [31:0] per_data_in,
  output logic [1:0]  per_data_write_n,
  output logic [1:0]  per_data_read_n,
  input  logic [31:0] per_data_out,
  input  logic        per_data_ready
);

  // state  | meaning
  // IDLE   | cmd_ready high, waiting for a command
  // ACCESS | strobe driven, waiting for per_data_ready or timeout
  // RESP   | response held until rsp_ready
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [5:0]  per_address_q, per_address_d;
  logic [31:0] per_data_in_q, per_data_in_d;
  logic [1:0]  write_n_q, write_n_d;
  logic [1:0]  read_n_q, read_n_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] rdata_masked;

  always_comb begin
    case (size_q)
      2'b00:   rdata_masked = {24'b0, per_data_out[7:0]};
      2'b01:   rdata_masked = {16'b0, per_data_out[15:0]};
      default: rdata_masked = per_data_out;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    per_address_d = per_address_q;
    per_data_in_d = per_data_in_q;
    write_n_d     = write_n_q;
    read_n_d      = read_n_q;
    write_d       = write_q;
    size_d        = size_q;
    cnt_d         = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          write_d       = cmd_write;
          size_d        = cmd_size;
          per_address_d = cmd_addr;
          per_data_in_d = cmd_wdata;
          cmd_ready_d   = 1'b0;
          if (cmd_size == 2'b11) begin
            // Illegal size never touches the peripheral.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'b0;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
            if (cmd_write) write_n_d = cmd_size;
            else           read_n_d  = cmd_size;
          end
        end
      end
      ST_ACCESS: begin
        if (per_data_ready) begin
          state_d     = ST_RESP;
          write_n_d   = 2'b11;
          read_n_d    = 2'b11;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = write_q ? 32'b0 : rdata_masked;
        end else if (TIMEOUT_CYCLES != 0 && (int'(cnt_q) + 1) == TIMEOUT_CYCLES) begin
          state_d     = ST_RESP;
          write_n_d   = 2'b11;
          read_n_d    = 2'b11;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'b0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'b0;
      rsp_err_q     <= 1'b0;
      per_address_q <= 6'b0;
      per_data_in_q <= 32'b0;
      write_n_q     <= 2'b11;
      read_n_q      <= 2'b11;
      write_q       <= 1'b0;
      size_q        <= 2'b00;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      per_address_q <= per_address_d;
      per_data_in_q <= per_data_in_d;
      write_n_q     <= write_n_d;
      read_n_q      <= read_n_d;
      write_q       <= write_d;
      size_q        <= size_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_err          = rsp_err_q;
  assign per_address      = per_address_q;
  assign per_data_in      = per_data_in_q;
  assign per_data_write_n = write_n_q;
  assign per_data_read_n  = read_n_q;

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Scoreboard bench for tqvp_bus_initiator: directed commands push expected responses,
// a monitor pops them on each response handshake; a strobe monitor records strobe runs.
module tb_tqvp_bus_initiator;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
  logic [1:0]  cmd_size = 2'b00;
  logic [5:0]  cmd_addr = 6'd0;
  logic [31:0] cmd_wdata = 32'd0, per_data_out = 32'd0;
  logic        cmd_ready, rsp_valid, rsp_err, per_data_ready;
  logic [31:0] rsp_rdata, per_data_in;
  logic [5:0]  per_address;
  logic [1:0]  per_data_write_n, per_data_read_n;

  always #5 clk = ~clk;

  tqvp_bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .per_address(per_address), .per_data_in(per_data_in),
    .per_data_write_n(per_data_write_n), .per_data_read_n(per_data_read_n),
    .per_data_out(per_data_out), .per_data_ready(per_data_ready)
  );

  int checks = 0, errors = 0;

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;

  // Peripheral model: data_ready rises after pwait strobe cycles.
  int pwait = 0;
  int sc;
  wire stb_active = (per_data_write_n != 2'b11) || (per_data_read_n != 2'b11);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          sc <= 0;
    else if (stb_active) sc <= sc + 1;
    else                 sc <= 0;
  end
  assign per_data_ready = stb_active && (sc >= pwait);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: got rdata %h err %b expected no response", rsp_rdata, rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
      end
    end
  end

  int run = 0, stb_len = 0, stb_events = 0;
  logic [1:0]  last_w, last_r;
  logic [5:0]  last_addr;
  logic [31:0] last_din;
  always @(negedge clk) begin
    if (!rst_n) run = 0;
    else if (stb_active) begin
      checks++;
      if (per_data_write_n != 2'b11 && per_data_read_n != 2'b11) begin
        errors++;
        $display("FAIL strobe_exclusive: got w=%b r=%b expected one idle", per_data_write_n, per_data_read_n);
      end
      run++;
      last_w = per_data_write_n; last_r = per_data_read_n;
      last_addr = per_address;   last_din = per_data_in;
    end else if (run != 0) begin
      stb_len = run; run = 0; stb_events++;
    end
  end

  task automatic accept(input logic w, input logic [1:0] sz, input logic [5:0] a,
                        input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_size = sz; cmd_addr = a; cmd_wdata = wd;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got cmd_ready %b expected 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int elat);
    int lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 100);
    chk("rsp_latency", lat, elat);
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic [5:0] a,
                       input logic [31:0] wd, input logic [31:0] pdo, input int wt,
                       input logic [31:0] er, input logic ee, input int elat, input int elen);
    int ev0 = stb_events;
    per_data_out = pdo; pwait = wt;
    exp_q.push_back('{rdata: er, err: ee});
    accept(w, sz, a, wd);
    wait_rsp(elat);
    @(negedge clk);
    if (elen == 0) chk("strobe_events", stb_events, ev0);
    else begin
      chk("strobe_events", stb_events, ev0 + 1);
      chk("strobe_len", stb_len, elen);
      chk("strobe_w", {30'b0, last_w}, {30'b0, (w ? sz : 2'b11)});
      chk("strobe_r", {30'b0, last_r}, {30'b0, (w ? 2'b11 : sz)});
      chk("strobe_addr", {26'b0, last_addr}, {26'b0, a});
      if (w) chk("strobe_wdata", last_din, wd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ev0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_strobes", {28'b0, per_data_write_n, per_data_read_n}, 32'hF);
    chk("reset_addr", {26'b0, per_address}, 32'd0);

    // write, read 8b, read 16b with waits, read 32b, write timeout
    issue(1'b1, 2'b10, 6'd0,  32'hDEADBEEF, 32'h0,        0,    32'h0,        1'b0, 2,  1);
    issue(1'b0, 2'b00, 6'd4,  32'h0,        32'hA5A51234, 0,    32'h00000034, 1'b0, 2,  1);
    issue(1'b0, 2'b01, 6'd7,  32'h0,        32'hDEADBEEF, 3,    32'h0000BEEF, 1'b0, 5,  4);
    issue(1'b0, 2'b10, 6'd63, 32'h0,        32'hCAFEF00D, 0,    32'hCAFEF00D, 1'b0, 2,  1);
    issue(1'b1, 2'b10, 6'd12, 32'h13572468, 32'hFFFFFFFF, 1000, 32'h0,        1'b1, 17, 16);
    chk("addr_held", {26'b0, per_address}, 32'd12);
    chk("wdata_held", per_data_in, 32'h13572468);

    // illegal size with back-pressured response
    ev0 = stb_events;
    rsp_ready = 1'b0;
    exp_q.push_back('{rdata: 32'h0, err: 1'b1});
    accept(1'b0, 2'b11, 6'd5, 32'h0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_size = 2'b10;
    wait_rsp(1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'd0);
      chk("hold_rsp_err", {31'b0, rsp_err}, 32'd1);
      chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("illegal_no_strobe", stb_events, ev0);
    chk("illegal_rsp_popped", exp_q.size(), 0);

    // reset during a wait state drops the transaction
    pwait = 1000;
    accept(1'b0, 2'b01, 6'd3, 32'h0);
    repeat (3) @(negedge clk);
    chk("pre_reset_strobe", {30'b0, per_data_read_n}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_strobes", {28'b0, per_data_write_n, per_data_read_n}, 32'hF);
    chk("reset_mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    issue(1'b0, 2'b10, 6'd9, 32'h0, 32'h12345678, 1, 32'h12345678, 1'b0, 3, 2);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
